div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_ctrl_if.sv | 40 ++++
 rtl/div_ctrl_div.sv | 84 ++++++++
 rtl/div_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the divide controller and its iterative divider.
//   DATA_W      : operand / result width
//   DIV_LATENCY : cycles from the divider start pulse to its complete pulse
//   CNT_W       : width of the iteration / latency counters
//   state_e     : controller FSM encoding
//   cond_neg()  : two's-complement negate when the select bit is set
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

   localparam int DATA_W      = 32;
   localparam int DIV_LATENCY = 33;
   localparam int CNT_W       = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_BUSY  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic [DATA_W-1:0] cond_neg(input logic          i_neg,
                                                  input logic [DATA_W-1:0] i_val);
      return i_neg ? (~i_val + 1'b1) : i_val;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Request / response bundle of the divide controller.
//   req_valid, req_ready, req_signed, req_x, req_y : request channel
//   cancel                                         : pipeline flush
//   resp_valid, resp_ready, resp_q, resp_r         : response channel
//   busy                                           : controller not idle
// Modports: master (requester side), slave (div_ctrl side).
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge; the sink may raise or drop ready at any time, and
// ready never depends on valid.
// -----------------------------------------------------------------------------
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_signed;
   logic [DATA_W-1:0] req_x;
   logic [DATA_W-1:0] req_y;
   logic              cancel;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_q;
   logic [DATA_W-1:0] resp_r;
   logic              busy;

   modport master (
      output req_valid, req_signed, req_x, req_y, cancel, resp_ready,
      input  req_ready, resp_valid, resp_q, resp_r, busy
   );

   modport slave (
      input  req_valid, req_signed, req_x, req_y, cancel, resp_ready,
      output req_ready, resp_valid, resp_q, resp_r, busy
   );

endinterface

// File: rtl/div_ctrl_div.sv
// -----------------------------------------------------------------------------
// div
// Iterative restoring divider, one quotient bit per cycle.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_div          : start pulse, samples operand magnitudes
//   i_signed       : 1 = signed operands
//   i_x, i_y       : dividend, divisor (must stay stable until complete)
//   o_complete     : one-cycle pulse, DIV_LATENCY cycles after the start pulse
//   o_s, o_r       : quotient and remainder, valid while o_complete is high
// Sign correction is applied combinationally from the live i_x/i_y/i_signed.
// Divide by zero yields quotient all-ones and remainder equal to the dividend.
// -----------------------------------------------------------------------------
module div
   import div_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_div,
   input  logic              i_signed,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_y,
   output logic              o_complete,
   output logic [DATA_W-1:0] o_s,
   output logic [DATA_W-1:0] o_r
);

   logic              r_active;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvs;

   logic              w_x_neg;
   logic              w_y_neg;
   logic              w_q_neg;
   logic [DATA_W-1:0] w_x_mag;
   logic [DATA_W-1:0] w_y_mag;
   logic [DATA_W:0]   w_rem_sh;
   logic [DATA_W:0]   w_diff;
   logic              w_ge;

   assign w_x_neg = i_signed & i_x[DATA_W-1];
   assign w_y_neg = i_signed & i_y[DATA_W-1];
   assign w_x_mag = cond_neg(w_x_neg, i_x);
   assign w_y_mag = cond_neg(w_y_neg, i_y);

   // Shift the next dividend bit into the partial remainder and try a subtract;
   // the borrow bit of the wide difference tells whether it fits.
   assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_ge     = ~w_diff[DATA_W];

   // Zero divisor keeps the raw all-ones quotient regardless of signs.
   assign w_q_neg    = (w_x_neg ^ w_y_neg) & (i_y != '0);
   assign o_complete = r_active & (r_cnt == '0);
   assign o_s        = cond_neg(w_q_neg, r_quo);
   assign o_r        = cond_neg(w_x_neg, r_rem);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dvs    <= '0;
      end else if (i_div) begin
         r_active <= 1'b1;
         r_cnt    <= CNT_W'(DATA_W);
         r_quo    <= w_x_mag;
         r_rem    <= '0;
         r_dvs    <= w_y_mag;
      end else if (r_active) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
         end else begin
            // complete was high this cycle; retire the operation
            r_active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Controller that sequences one divide at a time through the iterative
// divider, with flush support and a held response.
//   div_clk     : clock
//   resetn      : asynchronous active-low reset
//   bus         : div_ctrl_if.slave request/response bundle
//   o_dbg_state : current FSM state, for observation only
// Optional feature macro: DIV_CTRL_ZERO_BYPASS_EN -- a zero divisor skips the
// divider and answers in the cycle after acceptance with q=all-ones, r=x.
// -----------------------------------------------------------------------------
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic       div_clk,
   input  logic       resetn,
   div_ctrl_if.slave  bus,
   output state_e     o_dbg_state
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DATA_W-1:0] r_x;
   logic [DATA_W-1:0] r_y;
   logic              r_signed;
   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_r;
   logic [CNT_W-1:0]  r_chk_cnt;

   logic              w_req_ready;
   logic              w_accept;
   logic              w_div_start;
   logic              w_capture;
   logic              w_bypass;
   logic              w_div_complete;
   logic [DATA_W-1:0] w_div_s;
   logic [DATA_W-1:0] w_div_r;

   // Operands come from registers so the divider's combinational sign
   // correction sees stable values for the whole operation.
   div u_div (
      .i_clk      (div_clk),
      .i_rst_n    (resetn),
      .i_div      (w_div_start),
      .i_signed   (r_signed),
      .i_x        (r_x),
      .i_y        (r_y),
      .o_complete (w_div_complete),
      .o_s        (w_div_s),
      .o_r        (w_div_r)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_div_start = 1'b0;
      w_capture   = 1'b0;
      w_bypass    = 1'b0;
      w_req_ready = (r_state == ST_IDLE) & ~bus.cancel;
      w_accept    = bus.req_valid & w_req_ready;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef DIV_CTRL_ZERO_BYPASS_EN
               if (bus.req_y == '0) begin
                  w_bypass    = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_ISSUE;
               end
`else
               w_state_nxt = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            // The start pulse goes out even when cancelled so the divider
            // always runs its full count and DRAIN can wait for it.
            w_div_start = 1'b1;
            w_state_nxt = bus.cancel ? ST_DRAIN : ST_BUSY;
         end
         ST_BUSY: begin
            if (bus.cancel) begin
               w_state_nxt = w_div_complete ? ST_IDLE : ST_DRAIN;
            end else if (w_div_complete) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (w_div_complete) w_state_nxt = ST_IDLE;
         end
         ST_DONE: begin
            // cancel and resp_ready both leave DONE; cancel simply drops it
            if (bus.cancel || bus.resp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge div_clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_signed  <= 1'b0;
         r_q       <= '0;
         r_r       <= '0;
         r_chk_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_x      <= bus.req_x;
            r_y      <= bus.req_y;
            r_signed <= bus.req_signed;
         end
         if (w_capture) begin
            r_q <= w_div_s;
            r_r <= w_div_r;
         end else if (w_bypass) begin
            r_q <= '1;
            r_r <= bus.req_x;
         end
         // Counts down from the start pulse; complete must coincide with 1.
         if (w_div_start) begin
            r_chk_cnt <= CNT_W'(DIV_LATENCY);
         end else if (r_chk_cnt != '0) begin
            r_chk_cnt <= r_chk_cnt - 1'b1;
         end
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = (r_state == ST_DONE);
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.resp_q     = r_q;
   assign bus.resp_r     = r_r;
   assign o_dbg_state    = r_state;

   a_complete_timing: assert property (
      @(posedge div_clk) disable iff (!resetn)
         w_div_complete == (r_chk_cnt == CNT_W'(1))
   );

   a_complete_state: assert property (
      @(posedge div_clk) disable iff (!resetn)
         w_div_complete |-> (r_state == ST_BUSY || r_state == ST_DRAIN)
   );

endmodule
